// File: rtl/rp8_pkg.sv
// rtl/rp8_pkg.sv - shared types and default widths for the rp8 data-bus arbiter
package rp8_pkg;

    localparam int DAW_DEF = 13;
    localparam int IDW_DEF = 6;
    localparam int DW_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/rp8_arb_sel.sv
// rtl/rp8_arb_sel.sv - two-input tie-break selector, round-robin when RP8_BD_ARB_RR_EN is defined
module rp8_arb_sel
    import rp8_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req0,
    input  logic   req1,
    input  logic   upd,
    input  owner_t upd_own,
    output logic   gnt0,
    output logic   gnt1
);

`ifdef RP8_BD_ARB_RR_EN
    owner_t ptr;

    // Remember the master served last; reset value lets master 0 win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= OWNER_M1;
        end else if (upd) begin
            ptr <= upd_own;
        end
    end

    // A tie goes to the master that was not served last
    always_comb begin
        gnt0 = req0;
        gnt1 = req1;
        if (req0 && req1) begin
            gnt0 = (ptr == OWNER_M1);
            gnt1 = (ptr == OWNER_M0);
        end
    end
`else
    logic unused_sel;
    assign unused_sel = &{1'b0, clk, rst, upd, upd_own};

    // Fixed priority: master 0 always wins a tie
    always_comb begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
    end
`endif

endmodule

// File: rtl/rp8_bd_arb.sv
// rtl/rp8_bd_arb.sv - two-master rp8 data-bus arbiter with locking and read routing (RP8_BD_ARB_RR_EN selects round-robin)
module rp8_bd_arb
    import rp8_pkg::*;
#(
    parameter int DAW = DAW_DEF,
    parameter int IDW = IDW_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           m0_req,
    input  logic           m0_lck,
    input  logic           m0_wen,
    input  logic [DAW-1:0] m0_adr,
    input  logic [IDW-1:0] m0_wid,
    input  logic [DW-1:0]  m0_wdt,
    output logic           m0_ack,
    output logic [DW-1:0]  m0_rdt,
    output logic [IDW-1:0] m0_rid,
    output logic           m0_ren,

    input  logic           m1_req,
    input  logic           m1_lck,
    input  logic           m1_wen,
    input  logic [DAW-1:0] m1_adr,
    input  logic [IDW-1:0] m1_wid,
    input  logic [DW-1:0]  m1_wdt,
    output logic           m1_ack,
    output logic [DW-1:0]  m1_rdt,
    output logic [IDW-1:0] m1_rid,
    output logic           m1_ren,

    output logic           s_req,
    output logic           s_wen,
    output logic [DAW-1:0] s_adr,
    output logic [DW-1:0]  s_wdt,
    input  logic [DW-1:0]  s_rdt
);

    state_t         state;
    state_t         state_nxt;
    logic           gnt0;
    logic           gnt1;
    logic           rsp_vld;
    owner_t         rsp_own;
    logic [IDW-1:0] rsp_id;

    rp8_arb_sel u_sel (
        .clk     (clk),
        .rst     (rst),
        .req0    (m0_req),
        .req1    (m1_req),
        .upd     (m0_ack | m1_ack),
        .upd_own (m1_ack),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    // Arbitration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decode and lock tracking; an owner leaves its lock whenever lck drops,
    // whether or not it transferred in that cycle
    always_comb begin
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                IDLE: begin
                    m0_ack = gnt0;
                    m1_ack = gnt1;
                    if (gnt0 && m0_lck) begin
                        state_nxt = OWN0;
                    end else if (gnt1 && m1_lck) begin
                        state_nxt = OWN1;
                    end
                end
                OWN0: begin
                    m0_ack = m0_req;
                    if (!m0_lck) begin
                        state_nxt = IDLE;
                    end
                end
                OWN1: begin
                    m1_ack = m1_req;
                    if (!m1_lck) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Slave mux: forward the acked master, drive zeros when idle
    always_comb begin
        s_req = m0_ack | m1_ack;
        s_wen = 1'b0;
        s_adr = '0;
        s_wdt = '0;
        if (m0_ack) begin
            s_wen = m0_wen;
            s_adr = m0_adr;
            s_wdt = m0_wdt;
        end else if (m1_ack) begin
            s_wen = m1_wen;
            s_adr = m1_adr;
            s_wdt = m1_wdt;
        end
    end

    // Read tracker: one outstanding response per cycle, matching the RAM's one-cycle latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld <= 1'b0;
            rsp_own <= OWNER_M0;
            rsp_id  <= '0;
        end else begin
            rsp_vld <= s_req & ~s_wen;
            rsp_own <= m1_ack;
            rsp_id  <= m1_ack ? m1_wid : m0_wid;
        end
    end

    // Response routing back to the issuing master
    always_comb begin
        m0_ren = rsp_vld & (rsp_own == OWNER_M0);
        m1_ren = rsp_vld & (rsp_own == OWNER_M1);
        m0_rid = m0_ren ? rsp_id : '0;
        m1_rid = m1_ren ? rsp_id : '0;
        m0_rdt = m0_ren ? s_rdt : '0;
        m1_rdt = m1_ren ? s_rdt : '0;
    end

endmodule

// File: tb/tb_rp8_bd_arb.sv
// tb/tb_rp8_bd_arb.sv - scoreboard bench for rp8_bd_arb
module tb_rp8_bd_arb;

    localparam int DAW = 13;
    localparam int IDW = 6;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;

    logic           m0_req, m0_lck, m0_wen;
    logic [DAW-1:0] m0_adr;
    logic [IDW-1:0] m0_wid;
    logic [DW-1:0]  m0_wdt;
    logic           m0_ack, m0_ren;
    logic [DW-1:0]  m0_rdt;
    logic [IDW-1:0] m0_rid;

    logic           m1_req, m1_lck, m1_wen;
    logic [DAW-1:0] m1_adr;
    logic [IDW-1:0] m1_wid;
    logic [DW-1:0]  m1_wdt;
    logic           m1_ack, m1_ren;
    logic [DW-1:0]  m1_rdt;
    logic [IDW-1:0] m1_rid;

    logic           s_req, s_wen;
    logic [DAW-1:0] s_adr;
    logic [DW-1:0]  s_wdt;
    logic [DW-1:0]  s_rdt;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic           own;
        logic [IDW-1:0] id;
        logic [DW-1:0]  dat;
        int             due;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_exp;

    logic [DW-1:0] ram     [0:(1<<DAW)-1];
    logic [DW-1:0] ref_mem [0:(1<<DAW)-1];

    always #5 clk = ~clk;

    rp8_bd_arb dut (
        .clk    (clk),    .rst    (rst),
        .m0_req (m0_req), .m0_lck (m0_lck), .m0_wen (m0_wen), .m0_adr (m0_adr),
        .m0_wid (m0_wid), .m0_wdt (m0_wdt), .m0_ack (m0_ack), .m0_rdt (m0_rdt),
        .m0_rid (m0_rid), .m0_ren (m0_ren),
        .m1_req (m1_req), .m1_lck (m1_lck), .m1_wen (m1_wen), .m1_adr (m1_adr),
        .m1_wid (m1_wid), .m1_wdt (m1_wdt), .m1_ack (m1_ack), .m1_rdt (m1_rdt),
        .m1_rid (m1_rid), .m1_ren (m1_ren),
        .s_req  (s_req),  .s_wen  (s_wen),  .s_adr  (s_adr),  .s_wdt  (s_wdt),
        .s_rdt  (s_rdt)
    );

    // Single-port synchronous RAM with one-cycle read latency
    always @(posedge clk) begin
        if (s_req) begin
            if (s_wen) ram[s_adr] <= s_wdt;
            s_rdt <= ram[s_adr];
        end
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Response scoreboard: each entry must appear exactly in its due cycle
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (sb.size() > 0 && sb[0].due < cyc_n) begin
                mon_exp = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missed: response own=%0d id=%h due cycle %0d never observed", mon_exp.own, mon_exp.id, mon_exp.due);
            end
            if (sb.size() > 0 && sb[0].due == cyc_n) begin
                mon_exp = sb.pop_front();
                checks++;
                if (mon_exp.own == 1'b0) begin
                    if (m0_ren !== 1'b1 || m0_rid !== mon_exp.id || m0_rdt !== mon_exp.dat || m1_ren !== 1'b0 || m1_rdt !== 8'h00) begin
                        errors++;
                        $display("FAIL rsp_m0: got m0 ren=%b rid=%h rdt=%h m1 ren=%b rdt=%h, want m0 1 %h %h m1 0 00",
                                 m0_ren, m0_rid, m0_rdt, m1_ren, m1_rdt, mon_exp.id, mon_exp.dat);
                    end
                end else begin
                    if (m1_ren !== 1'b1 || m1_rid !== mon_exp.id || m1_rdt !== mon_exp.dat || m0_ren !== 1'b0 || m0_rdt !== 8'h00) begin
                        errors++;
                        $display("FAIL rsp_m1: got m1 ren=%b rid=%h rdt=%h m0 ren=%b rdt=%h, want m1 1 %h %h m0 0 00",
                                 m1_ren, m1_rid, m1_rdt, m0_ren, m0_rdt, mon_exp.id, mon_exp.dat);
                    end
                end
            end else begin
                checks++;
                if (m0_ren !== 1'b0 || m1_ren !== 1'b0 || m0_rdt !== 8'h00 || m1_rdt !== 8'h00) begin
                    errors++;
                    $display("FAIL rsp_idle: got ren=%b/%b rdt=%h/%h, want 0/0 00/00", m0_ren, m1_ren, m0_rdt, m1_rdt);
                end
            end
        end
    end

    task automatic drive(input logic r0, input logic l0, input logic w0, input logic [DAW-1:0] a0,
                         input logic [IDW-1:0] i0, input logic [DW-1:0] d0,
                         input logic r1, input logic l1, input logic w1, input logic [DAW-1:0] a1,
                         input logic [IDW-1:0] i1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        m0_req = r0; m0_lck = l0; m0_wen = w0; m0_adr = a0; m0_wid = i0; m0_wdt = d0;
        m1_req = r1; m1_lck = l1; m1_wen = w1; m1_adr = a1; m1_wid = i1; m1_wdt = d1;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic expect_read(input logic own, input logic [IDW-1:0] id, input logic [DAW-1:0] adr);
        sb.push_back('{own, id, ref_mem[adr], cyc_n + 1});
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_ren !== 1'b0 || m1_ren !== 1'b0 ||
            m0_rid !== '0 || m1_rid !== '0 || m0_rdt !== '0 || m1_rdt !== '0 ||
            s_req !== 1'b0 || s_wen !== 1'b0 || s_adr !== '0 || s_wdt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b%b ren=%b%b rid=%h/%h rdt=%h/%h s=%b%b %h %h, want all zero",
                     m0_ack, m1_ack, m0_ren, m1_ren, m0_rid, m1_rid, m0_rdt, m1_rdt, s_req, s_wen, s_adr, s_wdt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic [3:0] n0, n1;
        logic       e0;
        n0 = '0;
        n1 = '0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b0, DAW'(13'h100 + n0), IDW'(6'h10 + n0), '0,
                  1'b1, 1'b0, 1'b0, DAW'(13'h200 + n1), IDW'(6'h20 + n1), '0);
`ifdef RP8_BD_ARB_RR_EN
            e0 = (k % 2 == 0);
`else
            e0 = 1'b1;
`endif
            checks++;
            if (m0_ack !== e0 || m1_ack !== !e0) begin
                errors++;
                $display("FAIL tie_ack[%0d]: got ack0=%b ack1=%b, want %b %b", k, m0_ack, m1_ack, e0, !e0);
            end
            if (e0) begin
                expect_read(1'b0, IDW'(6'h10 + n0), DAW'(13'h100 + n0));
                n0++;
            end else begin
                expect_read(1'b1, IDW'(6'h20 + n1), DAW'(13'h200 + n1));
                n1++;
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b0, 1'b1, 13'h1234, 6'h00, 8'hA5, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || s_req !== 1'b1 || s_wen !== 1'b1 || s_adr !== 13'h1234 || s_wdt !== 8'hA5) begin
            errors++;
            $display("FAIL wr_ack: got ack=%b%b s=%b%b %h %h, want 10 11 1234 a5", m0_ack, m1_ack, s_req, s_wen, s_adr, s_wdt);
        end
        ref_mem[13'h1234] = 8'hA5;
        drive(1'b1, 1'b0, 1'b0, 13'h1234, 6'h05, 8'h00, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b1 || s_req !== 1'b1 || s_wen !== 1'b0 || s_adr !== 13'h1234) begin
            errors++;
            $display("FAIL rd_ack: got ack0=%b s=%b%b %h, want 1 10 1234", m0_ack, s_req, s_wen, s_adr);
        end
        expect_read(1'b0, 6'h05, 13'h1234);
        idle();
        checks++;
        if (s_req !== 1'b0 || s_wen !== 1'b0 || s_adr !== '0 || s_wdt !== '0) begin
            errors++;
            $display("FAIL slave_idle: got s=%b%b %h %h, want 00 0000 00", s_req, s_wen, s_adr, s_wdt);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 1'b0, 13'h0301, 6'h01, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack0: got %b%b, want 10", m0_ack, m1_ack);
        end
        expect_read(1'b0, 6'h01, 13'h0301);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 13'h0302, 6'h02, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack1: got %b%b, want 01", m0_ack, m1_ack);
        end
        expect_read(1'b1, 6'h02, 13'h0302);
        drive(1'b1, 1'b0, 1'b0, 13'h0303, 6'h03, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack2: got %b%b, want 10", m0_ack, m1_ack);
        end
        expect_read(1'b0, 6'h03, 13'h0303);
        idle();
    endtask

    task automatic test_lock();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 13'h0401, 6'h31, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL lock_first: got %b%b, want 01", m0_ack, m1_ack);
        end
        expect_read(1'b1, 6'h31, 13'h0401);
        drive(1'b1, 1'b0, 1'b0, 13'h0410, 6'h0A, '0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || s_req !== 1'b0) begin
            errors++;
            $display("FAIL lock_hold: got ack=%b%b s_req=%b, want 00 0", m0_ack, m1_ack, s_req);
        end
        drive(1'b1, 1'b0, 1'b0, 13'h0410, 6'h0A, '0, 1'b1, 1'b1, 1'b0, 13'h0402, 6'h32, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL lock_second: got %b%b, want 01", m0_ack, m1_ack);
        end
        expect_read(1'b1, 6'h32, 13'h0402);
        drive(1'b1, 1'b0, 1'b0, 13'h0410, 6'h0A, '0, 1'b1, 1'b0, 1'b0, 13'h0403, 6'h33, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL lock_last: got %b%b, want 01", m0_ack, m1_ack);
        end
        expect_read(1'b1, 6'h33, 13'h0403);
        drive(1'b1, 1'b0, 1'b0, 13'h0410, 6'h0A, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got %b%b, want 10", m0_ack, m1_ack);
        end
        expect_read(1'b0, 6'h0A, 13'h0410);
        idle();
    endtask

    task automatic test_drop_lock();
        drive(1'b1, 1'b1, 1'b0, 13'h0040, 6'h21, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL own0_enter: got %b%b, want 10", m0_ack, m1_ack);
        end
        expect_read(1'b0, 6'h21, 13'h0040);
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 13'h0041, 6'h22, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL own0_stall: got %b%b, want 00", m0_ack, m1_ack);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 13'h0041, 6'h22, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL own0_drop: got %b%b, want 00", m0_ack, m1_ack);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 13'h0041, 6'h22, '0);
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL own0_exit: got %b%b, want 01", m0_ack, m1_ack);
        end
        expect_read(1'b1, 6'h22, 13'h0041);
        idle();
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 1'b0, 1'b0, 13'h1234, 6'h07, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (m0_ack !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_ack: got %b, want 1", m0_ack);
        end
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (m0_ack !== 1'b0 || s_req !== 1'b0 || m0_ren !== 1'b0) begin
            errors++;
            $display("FAIL rst_gate: got ack0=%b s_req=%b ren0=%b, want 0 0 0", m0_ack, s_req, m0_ren);
        end
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (m0_ren !== 1'b0 || m1_ren !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold_ren: got %b%b, want 00", m0_ren, m1_ren);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_ren !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: got m0_ren=%b, want 0", m0_ren);
        end
        drive(1'b1, 1'b0, 1'b0, 13'h0500, 6'h15, '0, 1'b1, 1'b0, 1'b0, 13'h0501, 6'h16, '0);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_tie: got %b%b, want 10", m0_ack, m1_ack);
        end
        expect_read(1'b0, 6'h15, 13'h0500);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << DAW); i++) begin
            ram[i]     = DW'(i) ^ 8'h5A;
            ref_mem[i] = DW'(i) ^ 8'h5A;
        end
        s_rdt  = '0;
        m0_req = 1'b0; m0_lck = 1'b0; m0_wen = 1'b0; m0_adr = '0; m0_wid = '0; m0_wdt = '0;
        m1_req = 1'b0; m1_lck = 1'b0; m1_wen = 1'b0; m1_adr = '0; m1_wid = '0; m1_wdt = '0;

        test_reset();
        test_tie();
        test_write_read();
        test_back_to_back();
        test_lock();
        test_drop_lock();
        test_reset_inflight();
        idle();
        idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
